// File: rtl/sum_collect_if.sv
// rtl/sum_collect_if.sv - result-capture stream and status bundle for sum_collect
interface sum_collect_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] sum_in;
    logic [DATA_W-1:0] idx_in;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_sum;
    logic [DATA_W-1:0] out_idx;
    logic [CNT_W-1:0]  count;
    logic [ACC_W-1:0]  acc;
    logic              overflow;
    logic              seq_err;

    modport master (
        output in_valid, sum_in, idx_in, out_ready,
        input  out_valid, out_sum, out_idx, count, acc, overflow, seq_err
    );

    modport slave (
        input  in_valid, sum_in, idx_in, out_ready,
        output out_valid, out_sum, out_idx, count, acc, overflow, seq_err
    );
endinterface

// File: rtl/sum_collect.sv
// rtl/sum_collect.sv - show-ahead result FIFO with idx sequence check and running sum
module sum_collect #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int ACC_W  = 8
) (
    input  logic         clk,
    input  logic         reset_L,
    sum_collect_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem_sum [DEPTH];
    logic [DATA_W-1:0] r_mem_idx [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ACC_W-1:0]  r_acc;
    logic              r_overflow;
    logic              r_seq_err;
    logic              r_have_prev;
    logic [DATA_W-1:0] r_prev_idx;

    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [DATA_W-1:0] w_exp_idx;

    // A pop frees the slot the same edge, so a full FIFO still accepts a push
    // when the consumer drains; an empty FIFO never pops.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop     = (r_count != '0) && bus.out_ready;
    assign w_push    = bus.in_valid && (!w_full || w_pop);
    assign w_drop    = bus.in_valid && w_full && !w_pop;
    assign w_exp_idx = r_prev_idx + DATA_W'(1);

    assign bus.out_valid = (r_count != '0);
    assign bus.out_sum   = r_mem_sum[r_rd_ptr];
    assign bus.out_idx   = r_mem_idx[r_rd_ptr];
    assign bus.count     = r_count;
    assign bus.acc       = r_acc;
    assign bus.overflow  = r_overflow;
    assign bus.seq_err   = r_seq_err;

    // Entry storage; cleared on reset so the head reads 0 while empty.
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_sum[i] <= '0;
                r_mem_idx[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_sum[r_wr_ptr] <= bus.sum_in;
            r_mem_idx[r_wr_ptr] <= bus.idx_in;
        end
    end

    // Read/write pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Accumulator, sticky flags and idx continuity track accepted pushes only.
    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            r_acc       <= '0;
            r_overflow  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_have_prev <= 1'b0;
            r_prev_idx  <= '0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (w_push) begin
                r_acc       <= r_acc + ACC_W'(bus.sum_in);
                r_have_prev <= 1'b1;
                r_prev_idx  <= bus.idx_in;
                if (r_have_prev && (bus.idx_in != w_exp_idx)) r_seq_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sum_collect.sv
// tb/tb_sum_collect.sv - table, directed and randomized checks of sum_collect
module tb_sum_collect;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int ACC_W  = 8;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    sum_collect_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W)) bus ();

    sum_collect #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk    (clk),
        .reset_L(reset_L),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] s;
        logic [3:0] i;
    } ent_t;

    ent_t m_q[$];
    int   m_acc;
    bit   m_ovf;
    bit   m_seq;
    bit   m_have;
    int   m_prev;

    typedef struct {
        bit rst; bit v; int s; int i; bit r;
        bit ev; int es; int ei; int ec; int ea; bit eo; bit eq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit v, int s, int i, bit r,
                                bit ev, int es, int ei, int ec, int ea, bit eo, bit eq);
        vec_t t;
        t.rst = rst; t.v = v; t.s = s; t.i = i; t.r = r;
        t.ev = ev; t.es = es; t.ei = ei; t.ec = ec; t.ea = ea; t.eo = eo; t.eq = eq;
        return t;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_acc  = 0;
        m_ovf  = 0;
        m_seq  = 0;
        m_have = 0;
        m_prev = 0;
    endtask

    // Behaviour of one rising edge expressed as queue operations.
    task automatic model_edge(bit v, int s, int i, bit r);
        bit pop;
        bit full;
        bit take;
        ent_t e;
        pop  = (m_q.size() != 0) && r;
        full = (m_q.size() == DEPTH);
        take = v && (!full || pop);
        if (pop) void'(m_q.pop_front());
        if (v && !take) m_ovf = 1;
        if (take) begin
            e.s = 4'(s);
            e.i = 4'(i);
            m_q.push_back(e);
            m_acc = (m_acc + s) % 256;
            if (m_have && (i != (m_prev + 1) % 16)) m_seq = 1;
            m_prev = i;
            m_have = 1;
        end
    endtask

    task automatic compare_model(string tag);
        chk({tag, ".valid"}, int'(bus.out_valid), (m_q.size() != 0) ? 1 : 0);
        if (m_q.size() != 0) begin
            chk({tag, ".sum"}, int'(bus.out_sum), int'(m_q[0].s));
            chk({tag, ".idx"}, int'(bus.out_idx), int'(m_q[0].i));
        end
        chk({tag, ".count"}, int'(bus.count), m_q.size());
        chk({tag, ".acc"}, int'(bus.acc), m_acc);
        chk({tag, ".overflow"}, int'(bus.overflow), int'(m_ovf));
        chk({tag, ".seq_err"}, int'(bus.seq_err), int'(m_seq));
    endtask

    // Called at a falling edge: drive, let one rising edge pass, check at next falling edge.
    task automatic cycle(string tag, bit v, int s, int i, bit r);
        bus.in_valid  = v;
        bus.sum_in    = 4'(s);
        bus.idx_in    = 4'(i);
        bus.out_ready = r;
        @(posedge clk);
        model_edge(v, s, i, r);
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.idx_in    = '0;
        bus.out_ready = 1'b0;
        reset_L = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b0;
    endtask

    initial begin
        int seq_i;
        int rmode;
        reset_L       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.sum_in    = '0;
        bus.idx_in    = '0;
        bus.out_ready = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b0;

        chk("rst.valid", int'(bus.out_valid), 0);
        chk("rst.count", int'(bus.count), 0);
        chk("rst.acc", int'(bus.acc), 0);
        chk("rst.overflow", int'(bus.overflow), 0);
        chk("rst.seq_err", int'(bus.seq_err), 0);
        chk("rst.sum", int'(bus.out_sum), 0);
        chk("rst.idx", int'(bus.out_idx), 0);

        // Basic stream, then fill-past-full, drain and post-drop sequence error.
        tbl.push_back(mk(1, 1,  5, 0, 1,  1,  5, 0, 1, 5,  0, 0));
        tbl.push_back(mk(0, 1,  9, 1, 1,  1,  9, 1, 1, 14, 0, 0));
        tbl.push_back(mk(0, 1, 15, 2, 1,  1, 15, 2, 1, 29, 0, 0));
        tbl.push_back(mk(0, 0,  0, 0, 1,  0,  0, 0, 0, 29, 0, 0));
        tbl.push_back(mk(1, 1,  1, 0, 0,  1,  1, 0, 1, 1,  0, 0));
        tbl.push_back(mk(0, 1,  1, 1, 0,  1,  1, 0, 2, 2,  0, 0));
        tbl.push_back(mk(0, 1,  1, 2, 0,  1,  1, 0, 3, 3,  0, 0));
        tbl.push_back(mk(0, 1,  1, 3, 0,  1,  1, 0, 4, 4,  0, 0));
        tbl.push_back(mk(0, 1,  1, 4, 0,  1,  1, 0, 4, 4,  1, 0));
        tbl.push_back(mk(0, 1,  1, 5, 0,  1,  1, 0, 4, 4,  1, 0));
        tbl.push_back(mk(0, 0,  0, 0, 1,  1,  1, 1, 3, 4,  1, 0));
        tbl.push_back(mk(0, 0,  0, 0, 1,  1,  1, 2, 2, 4,  1, 0));
        tbl.push_back(mk(0, 0,  0, 0, 1,  1,  1, 3, 1, 4,  1, 0));
        tbl.push_back(mk(0, 0,  0, 0, 1,  0,  0, 0, 0, 4,  1, 0));
        tbl.push_back(mk(0, 1,  1, 6, 0,  1,  1, 6, 1, 5,  1, 1));

        for (int k = 0; k < tbl.size(); k++) begin
            string tag;
            tag = $sformatf("tbl%0d", k);
            if (tbl[k].rst) do_reset();
            cycle(tag, tbl[k].v, tbl[k].s, tbl[k].i, tbl[k].r);
            chk({tag, ".t_valid"}, int'(bus.out_valid), int'(tbl[k].ev));
            if (tbl[k].ev) begin
                chk({tag, ".t_sum"}, int'(bus.out_sum), tbl[k].es);
                chk({tag, ".t_idx"}, int'(bus.out_idx), tbl[k].ei);
            end
            chk({tag, ".t_count"}, int'(bus.count), tbl[k].ec);
            chk({tag, ".t_acc"}, int'(bus.acc), tbl[k].ea);
            chk({tag, ".t_ovf"}, int'(bus.overflow), int'(tbl[k].eo));
            chk({tag, ".t_seq"}, int'(bus.seq_err), int'(tbl[k].eq));
        end

        // Full FIFO with simultaneous push and pop.
        do_reset();
        for (int k = 0; k < 4; k++) cycle("fill", 1, k + 2, k, 0);
        cycle("fullpp", 1, 6, 4, 1);
        chk("fullpp.count", int'(bus.count), 4);
        chk("fullpp.overflow", int'(bus.overflow), 0);
        chk("fullpp.head", int'(bus.out_idx), 1);
        for (int k = 0; k < 3; k++) cycle("fulldrain", 0, 0, 0, 1);
        chk("fullpp.tail_idx", int'(bus.out_idx), 4);
        chk("fullpp.tail_sum", int'(bus.out_sum), 6);
        cycle("fulldrain", 0, 0, 0, 1);

        // idx wrap modulo 16 is continuous.
        do_reset();
        cycle("wrap", 1, 1, 14, 1);
        cycle("wrap", 1, 1, 15, 1);
        cycle("wrap", 1, 1, 0, 1);
        cycle("wrap", 1, 1, 1, 1);
        chk("wrap.seq_err", int'(bus.seq_err), 0);

        // Gap raises sticky error; next contiguous sample keeps it set.
        do_reset();
        cycle("gap", 1, 2, 3, 1);
        cycle("gap", 1, 2, 4, 1);
        chk("gap.before", int'(bus.seq_err), 0);
        cycle("gap", 1, 2, 6, 1);
        chk("gap.after", int'(bus.seq_err), 1);
        cycle("gap", 1, 2, 7, 1);
        chk("gap.sticky", int'(bus.seq_err), 1);

        // Accumulator wraps modulo 256.
        do_reset();
        for (int k = 0; k < 20; k++) cycle("accwrap", 1, 15, k % 16, 1);
        chk("accwrap.acc", int'(bus.acc), 44);

        // Asynchronous reset with entries held and both flags set.
        do_reset();
        cycle("ar", 1, 3, 0, 0);
        cycle("ar", 1, 3, 1, 0);
        cycle("ar", 1, 3, 3, 0);
        cycle("ar", 1, 3, 4, 0);
        cycle("ar", 1, 3, 5, 0);
        cycle("ar", 0, 0, 0, 1);
        cycle("ar", 0, 0, 0, 1);
        chk("ar.pre_count", int'(bus.count), 2);
        chk("ar.pre_flags", int'({bus.overflow, bus.seq_err}), 3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        reset_L = 1'b1;
        #1;
        chk("ar.valid", int'(bus.out_valid), 0);
        chk("ar.count", int'(bus.count), 0);
        chk("ar.acc", int'(bus.acc), 0);
        chk("ar.overflow", int'(bus.overflow), 0);
        chk("ar.seq_err", int'(bus.seq_err), 0);
        chk("ar.sum", int'(bus.out_sum), 0);
        model_clear();
        @(negedge clk);
        reset_L = 1'b0;
        cycle("ar_after", 1, 3, 9, 0);
        chk("ar_after.seq_err", int'(bus.seq_err), 0);
        chk("ar_after.idx", int'(bus.out_idx), 9);

        // Randomized traffic against the queue model.
        do_reset();
        seq_i = 0;
        rmode = 2;
        for (int k = 0; k < 600; k++) begin
            bit v;
            bit r;
            int s;
            int i;
            if (k % 50 == 0) rmode = $urandom_range(0, 4);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) < rmode);
            s = $urandom_range(0, 15);
            i = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : seq_i;
            if (v) seq_i = (i + 1) % 16;
            cycle("rand", v, s, i, r);
            if (k == 300) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
